// File: rtl/mac_rx_frame_parser_if.sv
// rtl/mac_rx_frame_parser_if.sv - receive-side and frame-output signal bundle for mac_rx_frame_parser
//   master: drives rx_ce, mii_mode, rx_dv, rx_d, ts_in; observes out_* and st_*
//   slave : the parser; consumes rx_* / ts_in, drives out_valid/out_data and the st_* frame status
interface mac_rx_frame_parser_if #(
  parameter int TS_W = 32
) ();
  logic            rx_ce;
  logic            mii_mode;
  logic            rx_dv;
  logic [7:0]      rx_d;
  logic [TS_W-1:0] ts_in;

  logic            out_valid;
  logic [7:0]      out_data;

  logic            st_valid;
  logic [10:0]     st_len;
  logic            st_crc_ok;
  logic            st_short;
  logic            st_long;
  logic            st_align_err;
  logic [1:0]      st_class;
  logic [TS_W-1:0] st_ts;

  modport master (
    output rx_ce, mii_mode, rx_dv, rx_d, ts_in,
    input  out_valid, out_data, st_valid, st_len, st_crc_ok, st_short, st_long,
           st_align_err, st_class, st_ts
  );

  modport slave (
    input  rx_ce, mii_mode, rx_dv, rx_d, ts_in,
    output out_valid, out_data, st_valid, st_len, st_crc_ok, st_short, st_long,
           st_align_err, st_class, st_ts
  );
endinterface

// File: rtl/mac_rx_frame_parser.sv
// rtl/mac_rx_frame_parser.sv - MII/byte receive frame parser with CRC check, length/class status and SFD timestamp
//   clk, rst         : single clock, synchronous active-high reset
//   bus.rx_*         : sample strobe, MII/byte mode select, data valid and data
//   bus.ts_in        : free-running time counter, captured at SFD
//   bus.out_*        : one frame byte per pulse, DA first, FCS included
//   bus.st_*         : frame status, valid with the one-cycle st_valid pulse and held until the next
module mac_rx_frame_parser #(
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518,
  parameter logic [15:0] TTE_TYPE = 16'h0892,
  parameter logic [15:0] PTP_TYPE = 16'h88F7,
  parameter int          TS_W     = 32
) (
  input logic                  clk,
  input logic                  rst,
  mac_rx_frame_parser_if.slave bus
);

  typedef enum logic [1:0] {S_DROP, S_IDLE, S_PRE, S_DATA} state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] LEN_SAT     = 11'd2047;

  state_t          state_q, state_d;
  logic            mii_q, mii_d;
  logic            half_q, half_d;      // low nibble of an MII byte is held in nib_q
  logic [3:0]      nib_q, nib_d;
  logic [10:0]     len_q, len_d;
  logic [31:0]     crc_q, crc_d;
  logic [15:0]     etype_q, etype_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            st_valid_q, st_valid_d;
  logic [10:0]     st_len_q, st_len_d;
  logic            st_crc_ok_q, st_crc_ok_d;
  logic            st_short_q, st_short_d;
  logic            st_long_q, st_long_d;
  logic            st_align_q, st_align_d;
  logic [1:0]      st_class_q, st_class_d;
  logic [TS_W-1:0] st_ts_q, st_ts_d;

  logic       sym_pre, sym_sfd;
  logic [7:0] asm_byte;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Preamble/SFD symbols are single nibbles in MII mode, whole bytes otherwise.
  assign sym_pre  = mii_q ? (bus.rx_d[3:0] == 4'h5) : (bus.rx_d == 8'h55);
  assign sym_sfd  = mii_q ? (bus.rx_d[3:0] == 4'hD) : (bus.rx_d == 8'hD5);
  assign asm_byte = mii_q ? {bus.rx_d[3:0], nib_q} : bus.rx_d;

  always_comb begin
    state_d      = state_q;
    mii_d        = mii_q;
    half_d       = half_q;
    nib_d        = nib_q;
    len_d        = len_q;
    crc_d        = crc_q;
    etype_d      = etype_q;
    ts_d         = ts_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    st_valid_d   = 1'b0;
    st_len_d     = st_len_q;
    st_crc_ok_d  = st_crc_ok_q;
    st_short_d   = st_short_q;
    st_long_d    = st_long_q;
    st_align_d   = st_align_q;
    st_class_d   = st_class_q;
    st_ts_d      = st_ts_q;

    if (bus.rx_ce) begin
      case (state_q)
        S_DROP: if (!bus.rx_dv) state_d = S_IDLE;
        S_IDLE: begin
          mii_d = bus.mii_mode;
          if (bus.rx_dv) state_d = S_PRE;
        end
        S_PRE: begin
          if (!bus.rx_dv) begin
            state_d = S_IDLE;
          end else if (sym_sfd) begin
            state_d = S_DATA;
            crc_d   = 32'hFFFF_FFFF;
            len_d   = '0;
            half_d  = 1'b0;
            etype_d = '0;
            ts_d    = bus.ts_in;
          end else if (!sym_pre) begin
            state_d = S_DROP;
          end
        end
        S_DATA: begin
          if (!bus.rx_dv) begin
            state_d     = S_IDLE;
            st_valid_d  = 1'b1;
            st_len_d    = len_q;
            st_crc_ok_d = (crc_q == CRC_RESIDUE);
            st_short_d  = (32'(len_q) < MIN_LEN);
            st_long_d   = (32'(len_q) > MAX_LEN);
            st_align_d  = mii_q & half_q;
            st_ts_d     = ts_q;
            if (len_q < 11'd14)           st_class_d = 2'd0;
            else if (etype_q == TTE_TYPE) st_class_d = 2'd1;
            else if (etype_q == PTP_TYPE) st_class_d = 2'd2;
            else                          st_class_d = 2'd0;
          end else if (mii_q && !half_q) begin
            nib_d  = bus.rx_d[3:0];
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            crc_d  = crc_upd(crc_q, asm_byte);
            if (len_q != LEN_SAT) len_d = len_q + 11'd1;
            // len_q is the index of this byte; oversize tails are counted but not forwarded
            if (32'(len_q) < MAX_LEN) begin
              out_valid_d = 1'b1;
              out_data_d  = asm_byte;
            end
            if (len_q == 11'd12) etype_d[15:8] = asm_byte;
            if (len_q == 11'd13) etype_d[7:0]  = asm_byte;
          end
        end
        default: state_d = S_DROP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DROP;
      mii_q       <= 1'b0;
      half_q      <= 1'b0;
      nib_q       <= '0;
      len_q       <= '0;
      crc_q       <= '0;
      etype_q     <= '0;
      ts_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      st_valid_q  <= 1'b0;
      st_len_q    <= '0;
      st_crc_ok_q <= 1'b0;
      st_short_q  <= 1'b0;
      st_long_q   <= 1'b0;
      st_align_q  <= 1'b0;
      st_class_q  <= '0;
      st_ts_q     <= '0;
    end else begin
      state_q     <= state_d;
      mii_q       <= mii_d;
      half_q      <= half_d;
      nib_q       <= nib_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      etype_q     <= etype_d;
      ts_q        <= ts_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      st_valid_q  <= st_valid_d;
      st_len_q    <= st_len_d;
      st_crc_ok_q <= st_crc_ok_d;
      st_short_q  <= st_short_d;
      st_long_q   <= st_long_d;
      st_align_q  <= st_align_d;
      st_class_q  <= st_class_d;
      st_ts_q     <= st_ts_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.st_valid     = st_valid_q;
  assign bus.st_len       = st_len_q;
  assign bus.st_crc_ok    = st_crc_ok_q;
  assign bus.st_short     = st_short_q;
  assign bus.st_long      = st_long_q;
  assign bus.st_align_err = st_align_q;
  assign bus.st_class     = st_class_q;
  assign bus.st_ts        = st_ts_q;

endmodule

// File: tb/tb_mac_rx_frame_parser.sv
// tb/tb_mac_rx_frame_parser.sv - directed self-checking bench for mac_rx_frame_parser
module tb_mac_rx_frame_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ts_cnt = 32'h1000_0000;

  mac_rx_frame_parser_if #(.TS_W(32)) bus ();

  mac_rx_frame_parser #(
    .MIN_LEN(64), .MAX_LEN(1518), .TTE_TYPE(16'h0892), .PTP_TYPE(16'h88F7), .TS_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts_cnt <= ts_cnt + 32'd1;
  assign bus.ts_in = ts_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame [0:2047];
  logic [7:0]  got   [0:2047];
  int          flen;
  int          ng = 0;      // total out_valid bytes seen
  int          nst = 0;     // total st_valid pulses seen
  int          ng0 = 0;
  int          nst0 = 0;
  int          mii_g = 0;
  int          ce_div_g = 1;
  logic [31:0] sfd_ts;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if ((ng - ng0) >= 0 && (ng - ng0) < 2048) got[ng - ng0] = bus.out_data;
      ng = ng + 1;
    end
    if (bus.st_valid === 1'b1) nst = nst + 1;
  end

  // Reflected CRC-32 evaluated one bit at a time.
  task automatic build_frame(input int n, input logic [15:0] etype, input bit bad_fcs);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      if (i < 6)       frame[i] = 8'h02 + 8'(i);
      else if (i < 12) frame[i] = 8'hA0 + 8'(i);
      else if (i == 12) frame[i] = etype[15:8];
      else if (i == 13) frame[i] = etype[7:0];
      else             frame[i] = 8'((i * 7 + 3) & 255);
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frame[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    if (bad_fcs) c = ~c;
    frame[n]   = c[7:0];
    frame[n+1] = c[15:8];
    frame[n+2] = c[23:16];
    frame[n+3] = c[31:24];
    flen = n + 4;
  endtask

  task automatic put(input logic dv, input logic [7:0] d);
    for (int k = 1; k < ce_div_g; k++) begin
      @(negedge clk);
      bus.rx_ce = 1'b0;
    end
    @(negedge clk);
    bus.rx_ce = 1'b1;
    bus.rx_dv = dv;
    bus.rx_d  = d;
  endtask

  task automatic put_byte(input logic [7:0] b);
    if (mii_g != 0) begin
      put(1'b1, {4'h0, b[3:0]});
      put(1'b1, {4'h0, b[7:4]});
    end else begin
      put(1'b1, b);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b0, 8'h00);
  endtask

  task automatic send_pre();
    for (int k = 0; k < 7; k++) put_byte(8'h55);
    put_byte(8'hD5);
    sfd_ts = bus.ts_in;
  endtask

  // Full frame from frame[]; mii_mode pin is flipped mid-frame, which the parser must ignore.
  task automatic rx_frame(input bit extra_nib);
    bus.mii_mode = (mii_g != 0);
    idle(4);
    ng0  = ng;
    nst0 = nst;
    send_pre();
    bus.mii_mode = (mii_g == 0);
    for (int i = 0; i < flen; i++) put_byte(frame[i]);
    if (extra_nib) put(1'b1, 8'h0A);
    put(1'b0, 8'h00);
    bus.mii_mode = (mii_g != 0);
    idle(6);
  endtask

  task automatic count_bad(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) if (got[i] !== frame[i]) bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL rst_st_valid got %b exp 0", bus.st_valid); end
    checks++; if (bus.st_len !== 11'd0) begin errors++; $display("FAIL rst_st_len got %0d exp 0", bus.st_len); end
    checks++; if ({bus.st_crc_ok, bus.st_short, bus.st_long, bus.st_align_err, bus.st_class} !== 6'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 000000", {bus.st_crc_ok, bus.st_short, bus.st_long, bus.st_align_err, bus.st_class});
    end
    checks++; if (bus.st_ts !== 32'd0) begin errors++; $display("FAIL rst_st_ts got %h exp 0", bus.st_ts); end
    rst = 1'b0;
  endtask

  task automatic test_ptp_byte();
    int bad;
    mii_g = 0; ce_div_g = 1;
    build_frame(100, 16'h88F7, 1'b0);
    rx_frame(1'b0);
    count_bad(104, bad);
    checks++; if (ng - ng0 !== 104) begin errors++; $display("FAIL ptp_nbytes got %0d exp 104", ng - ng0); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ptp_bytes got %0d wrong exp 0", bad); end
    checks++; if (nst - nst0 !== 1) begin errors++; $display("FAIL ptp_st_pulses got %0d exp 1", nst - nst0); end
    checks++; if (bus.st_len !== 11'd104) begin errors++; $display("FAIL ptp_len got %0d exp 104", bus.st_len); end
    checks++; if (bus.st_crc_ok !== 1'b1) begin errors++; $display("FAIL ptp_crc_ok got %b exp 1", bus.st_crc_ok); end
    checks++; if (bus.st_class !== 2'd2) begin errors++; $display("FAIL ptp_class got %0d exp 2", bus.st_class); end
    checks++; if ({bus.st_short, bus.st_long, bus.st_align_err} !== 3'b000) begin
      errors++; $display("FAIL ptp_flags got %b exp 000", {bus.st_short, bus.st_long, bus.st_align_err});
    end
    checks++; if (bus.st_ts !== sfd_ts) begin errors++; $display("FAIL ptp_ts got %h exp %h", bus.st_ts, sfd_ts); end
  endtask

  task automatic test_bad_fcs();
    mii_g = 0; ce_div_g = 1;
    build_frame(100, 16'h88F7, 1'b1);
    rx_frame(1'b0);
    checks++; if (bus.st_crc_ok !== 1'b0) begin errors++; $display("FAIL badfcs_crc_ok got %b exp 0", bus.st_crc_ok); end
    checks++; if (bus.st_len !== 11'd104) begin errors++; $display("FAIL badfcs_len got %0d exp 104", bus.st_len); end
    checks++; if ({bus.st_class, bus.st_short, bus.st_long} !== 4'b1000) begin
      errors++; $display("FAIL badfcs_fields got %b exp 1000", {bus.st_class, bus.st_short, bus.st_long});
    end
  endtask

  task automatic test_short_long();
    int bad;
    mii_g = 0; ce_div_g = 1;
    build_frame(59, 16'h0800, 1'b0);
    rx_frame(1'b0);
    checks++; if (bus.st_len !== 11'd63) begin errors++; $display("FAIL short_len got %0d exp 63", bus.st_len); end
    checks++; if (bus.st_short !== 1'b1) begin errors++; $display("FAIL short_flag got %b exp 1", bus.st_short); end
    checks++; if (bus.st_class !== 2'd0) begin errors++; $display("FAIL short_class got %0d exp 0", bus.st_class); end
    checks++; if (bus.st_crc_ok !== 1'b1) begin errors++; $display("FAIL short_crc_ok got %b exp 1", bus.st_crc_ok); end

    build_frame(1515, 16'h0892, 1'b0);
    rx_frame(1'b0);
    count_bad(1518, bad);
    checks++; if (ng - ng0 !== 1518) begin errors++; $display("FAIL long_nbytes got %0d exp 1518", ng - ng0); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL long_bytes got %0d wrong exp 0", bad); end
    checks++; if (bus.st_len !== 11'd1519) begin errors++; $display("FAIL long_len got %0d exp 1519", bus.st_len); end
    checks++; if ({bus.st_long, bus.st_short} !== 2'b10) begin errors++; $display("FAIL long_flags got %b exp 10", {bus.st_long, bus.st_short}); end
    checks++; if (bus.st_class !== 2'd1) begin errors++; $display("FAIL long_class got %0d exp 1", bus.st_class); end
  endtask

  task automatic test_mii();
    int bad;
    mii_g = 1; ce_div_g = 2;
    build_frame(100, 16'h0892, 1'b0);
    rx_frame(1'b0);
    count_bad(104, bad);
    checks++; if (ng - ng0 !== 104) begin errors++; $display("FAIL mii_nbytes got %0d exp 104", ng - ng0); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mii_bytes got %0d wrong exp 0", bad); end
    checks++; if (bus.st_len !== 11'd104) begin errors++; $display("FAIL mii_len got %0d exp 104", bus.st_len); end
    checks++; if (bus.st_crc_ok !== 1'b1) begin errors++; $display("FAIL mii_crc_ok got %b exp 1", bus.st_crc_ok); end
    checks++; if (bus.st_class !== 2'd1) begin errors++; $display("FAIL mii_class got %0d exp 1", bus.st_class); end
    checks++; if (bus.st_align_err !== 1'b0) begin errors++; $display("FAIL mii_align got %b exp 0", bus.st_align_err); end
    checks++; if (bus.st_ts !== sfd_ts) begin errors++; $display("FAIL mii_ts got %h exp %h", bus.st_ts, sfd_ts); end

    rx_frame(1'b1);
    checks++; if (bus.st_align_err !== 1'b1) begin errors++; $display("FAIL mii_odd_align got %b exp 1", bus.st_align_err); end
    checks++; if (bus.st_len !== 11'd104) begin errors++; $display("FAIL mii_odd_len got %0d exp 104", bus.st_len); end
    checks++; if (nst - nst0 !== 1) begin errors++; $display("FAIL mii_odd_pulses got %0d exp 1", nst - nst0); end
    mii_g = 0; ce_div_g = 1;
    bus.mii_mode = 1'b0;
  endtask

  task automatic test_rst_mid_frame();
    mii_g = 0; ce_div_g = 1;
    build_frame(100, 16'h88F7, 1'b0);
    bus.mii_mode = 1'b0;
    idle(4);
    ng0 = ng; nst0 = nst;
    send_pre();
    for (int i = 0; i < 50; i++) put_byte(frame[i]);
    @(negedge clk);
    rst = 1'b1; bus.rx_ce = 1'b1; bus.rx_dv = 1'b1; bus.rx_d = frame[50];
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.st_len !== 11'd0) begin errors++; $display("FAIL rstmid_clear_len got %0d exp 0", bus.st_len); end
    rst = 1'b0;
    // rx_dv is still high at release: a complete frame follows without a gap and must be ignored
    send_pre();
    for (int i = 0; i < flen; i++) put_byte(frame[i]);
    put(1'b0, 8'h00);
    idle(6);
    checks++; if (ng - ng0 !== 50) begin errors++; $display("FAIL rstmid_nbytes got %0d exp 50", ng - ng0); end
    checks++; if (nst - nst0 !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", nst - nst0); end
    rx_frame(1'b0);
    checks++; if ((nst - nst0 !== 1) || (bus.st_len !== 11'd104) || (bus.st_crc_ok !== 1'b1)) begin
      errors++; $display("FAIL rstmid_next got pulses %0d len %0d crc %b exp 1 104 1", nst - nst0, bus.st_len, bus.st_crc_ok);
    end
  endtask

  task automatic test_preamble_abort();
    mii_g = 0; ce_div_g = 1;
    bus.mii_mode = 1'b0;
    build_frame(100, 16'h88F7, 1'b0);
    idle(4);
    ng0 = ng; nst0 = nst;
    for (int k = 0; k < 4; k++) put_byte(8'h55);
    idle(6);
    checks++; if ((ng - ng0 !== 0) || (nst - nst0 !== 0)) begin
      errors++; $display("FAIL pre_dvfall got bytes %0d pulses %0d exp 0 0", ng - ng0, nst - nst0);
    end
    put_byte(8'h55); put_byte(8'h55); put_byte(8'h57);
    for (int k = 0; k < 4; k++) put_byte(8'h55);
    put_byte(8'hD5);
    for (int i = 0; i < 20; i++) put_byte(frame[i]);
    put(1'b0, 8'h00);
    idle(6);
    checks++; if ((ng - ng0 !== 0) || (nst - nst0 !== 0)) begin
      errors++; $display("FAIL pre_bad57 got bytes %0d pulses %0d exp 0 0", ng - ng0, nst - nst0);
    end
    rx_frame(1'b0);
    checks++; if ((ng - ng0 !== 104) || (bus.st_len !== 11'd104) || (bus.st_crc_ok !== 1'b1) || (bus.st_class !== 2'd2)) begin
      errors++; $display("FAIL pre_next got bytes %0d len %0d crc %b class %0d exp 104 104 1 2",
                         ng - ng0, bus.st_len, bus.st_crc_ok, bus.st_class);
    end
  endtask

  initial begin
    bus.rx_ce    = 1'b0;
    bus.mii_mode = 1'b0;
    bus.rx_dv    = 1'b0;
    bus.rx_d     = 8'h00;
    test_reset();
    test_ptp_byte();
    test_bad_fcs();
    test_short_long();
    test_mii();
    test_rst_mid_frame();
    test_preamble_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
